// File: rtl/filter_pkg.sv
// Shared types and defaults for the FIR coefficient-load path.
package filter_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_WAIT_REL
  } load_state_t;

  localparam int TAP_DW        = 16;
  localparam int NTAPS_DEFAULT = 16;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);
  // last = index of the most recent winner; reset value 1 favors requester 0
  logic last;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (reset)                 last <= 1'b1;
    else if (accept && |req)   last <= grant[1];
  end
endmodule

// File: rtl/tap_load_arbiter.sv
// Arbitrates two requesters and streams one coefficient bank into the FIR taps.
module tap_load_arbiter
  import filter_pkg::*;
#(
  parameter int NTAPS  = NTAPS_DEFAULT,
  parameter int DW     = TAP_DW,
  parameter int NBANKS = 4,
  localparam int BW    = $clog2(NBANKS),
  localparam int KW    = $clog2(NTAPS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_req,
  input  logic [BW-1:0]    i_bank0,
  input  logic [BW-1:0]    i_bank1,
  input  logic             i_ce,
  output logic             o_mem_rd,
  output logic [BW+KW-1:0] o_mem_addr,
  input  logic [DW-1:0]    i_mem_data,
  output logic             o_tap_wr,
  output logic [KW-1:0]    o_tap_idx,
  output logic [DW-1:0]    o_tap,
  output logic             o_ce,
  output logic             o_busy,
  output logic [1:0]       o_done
);
  localparam logic [KW:0] K_LAST = (KW+1)'(NTAPS);

  load_state_t   state, state_n;
  logic [KW:0]   k, k_n;
  logic [BW-1:0] bank, bank_n;
  logic          g, g_n;
  logic          accept;
  logic [1:0]    grant;

  rr_arb2 u_arb (
    .clk    (i_clk),
    .reset  (i_reset),
    .req    (i_req),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      k     <= '0;
      bank  <= '0;
      g     <= 1'b0;
    end else begin
      state <= state_n;
      k     <= k_n;
      bank  <= bank_n;
      g     <= g_n;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    bank_n  = bank;
    g_n     = g;
    accept  = 1'b0;
    case (state)
      S_IDLE: if (|i_req) begin
        accept  = 1'b1;
        g_n     = grant[1];
        bank_n  = grant[1] ? i_bank1 : i_bank0;
        k_n     = '0;
        state_n = S_LOAD;
      end
      // k runs one past the last read so the final read's data gets written
      S_LOAD: begin
        if (k == K_LAST) state_n = S_DONE;
        else             k_n     = k + (KW+1)'(1);
      end
      S_DONE: begin
        k_n     = '0;
        state_n = i_req[g] ? S_WAIT_REL : S_IDLE;
      end
      S_WAIT_REL: if (!i_req[g]) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even before the state clears.
  always_comb begin
    o_mem_rd   = !i_reset && state == S_LOAD && k != K_LAST;
    o_mem_addr = o_mem_rd ? {bank, k[KW-1:0]} : '0;
    o_tap_wr   = !i_reset && state == S_LOAD && k != '0;
    o_tap_idx  = o_tap_wr ? k[KW-1:0] - KW'(1) : '0;
    o_tap      = o_tap_wr ? i_mem_data : '0;
    o_busy     = !i_reset && (state == S_LOAD || state == S_DONE);
    o_done     = (!i_reset && state == S_DONE) ? (g ? 2'b10 : 2'b01) : 2'b00;
    o_ce       = i_ce & ~o_busy;
  end
endmodule

// File: doc/tap_load_arbiter.md
TAP_LOAD_ARBITER -- requirements
Module: tap_load_arbiter

Interface
REQ-001 Parameter NTAPS, default 16: number of FIR taps written per load.
REQ-002 Parameter DW, default 16: coefficient width.
REQ-003 Parameter NBANKS, default 4: coefficient banks in memory (power of 2).
REQ-004 i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_req  in  2  per-requester load request, level; held until o_done pulse.
REQ-007 i_bank0, i_bank1  in  log2(NBANKS) each  bank selected by requester 0 and requester 1.
REQ-008 i_ce  in  1  upstream sample enable.
REQ-009 o_mem_rd  out  1  coefficient memory read strobe.
REQ-010 o_mem_addr  out  log2(NBANKS)+log2(NTAPS)  {bank, tap index}.
REQ-011 i_mem_data  in  DW  memory read data, valid exactly 1 cycle after o_mem_rd.
REQ-012 o_tap_wr  out  1  FIR tap write strobe, active high.
REQ-013 o_tap_idx  out  log2(NTAPS)  index of tap being written.
REQ-014 o_tap  out  DW  tap value to FIR.
REQ-015 o_ce  out  1  gated sample enable to FIR.
REQ-016 o_busy  out  1  load in progress.
REQ-017 o_done  out  2  one-cycle completion pulse, one-hot per requester.

Function
REQ-018 FSM states: IDLE, LOAD, DONE, WAIT_REL; LOAD holds tap counter k from 0 to NTAPS.
REQ-019 IDLE: if any i_req bit is high, accept one requester (grant g), latch its bank, and go to LOAD with k=0. Otherwise stay in IDLE.
REQ-020 Arbitration is round-robin. If both requests are high, grant the requester not granted last. Out of reset, requester 0 has priority.
REQ-021 Acceptance cycle is T. o_mem_rd=1 and o_mem_addr={bank,k} for cycles T+1..T+NTAPS, with k=0..NTAPS-1.
REQ-022 o_tap_wr=1 for cycles T+2..T+NTAPS+1. In the same cycles o_tap=i_mem_data and o_tap_idx=k-1, giving exactly NTAPS writes in ascending index order.
REQ-023 DONE occupies cycle T+NTAPS+2; o_done[g]=1 for that cycle only.
REQ-024 After DONE, go to WAIT_REL if i_req[g] is still high, else go to IDLE. WAIT_REL returns to IDLE in the cycle after i_req[g] is sampled low.
REQ-025 o_busy=1 from T+1 through T+NTAPS+2 inclusive, and 0 otherwise.
REQ-026 o_ce = i_ce & ~o_busy (combinational), so no sample is clocked into the FIR during a load.
REQ-027 If i_req[g] drops during LOAD, the load still completes and o_done[g] still pulses.
REQ-028 Changes to i_bankN after acceptance are ignored until the next acceptance.
REQ-029 A request from the other requester that arrives during a load waits. It is arbitrated in IDLE, so at least one IDLE cycle separates back-to-back loads.
REQ-030 Latency from acceptance to o_done is NTAPS+2 cycles. Minimum spacing between acceptances is NTAPS+3 cycles.

Reset
REQ-031 While i_reset=1: state=IDLE, k=0, round-robin pointer favors requester 0.
REQ-032 While i_reset=1, these outputs are 0: o_mem_rd, o_mem_addr, o_tap_wr, o_tap_idx, o_tap, o_busy, o_done. o_ce follows i_ce.
REQ-033 Reset mid-load aborts the load with no o_done pulse. FIR contents are left partially written; restoring them is the requester's duty.

Structure
REQ-034 Shared package filter_pkg holds the state enum type, TAP_DW=16 and NTAPS_DEFAULT=16.
REQ-035 Round-robin selection is a sub-module rr_arb2 (2-input, combinational grant, registered last-grant pointer).

Verification
REQ-036 Single load: reset, then i_req=01 with i_bank0=2 at cycle 5. Addresses 32..47 are read at cycles 6..21. o_tap_wr is high at cycles 7..22 with idx 0..15. o_done=01 at cycle 23.
REQ-037 Contention: i_req=11 held, requester 0 released after each done. Grants alternate 0,1,0. Exactly one IDLE cycle separates loads.
REQ-038 CE gating: i_ce=1 constant during a load. o_ce is 0 for exactly NTAPS+2 cycles and 1 otherwise.
REQ-039 Request withdrawn: i_req[1] deasserted at T+4. All 16 writes still occur, o_done=10 pulses, FSM goes DONE->IDLE with no WAIT_REL.
REQ-040 Reset mid-load: i_reset=1 at T+8. The next cycle shows o_tap_wr=0, o_busy=0, and no o_done. After release, a new request is accepted with requester 0 priority.
REQ-041 Bank change: i_bank0 is changed at T+3. All 16 addresses use the bank latched at T.
